// File: rtl/game_pkg.sv
// Shared definitions for the reaction-time game sequencer.
//   state_t        : sequencer phases (IDLE, COUNT, ARMED, GO, DONE)
//   SEL_*          : 2-bit game_select codes consumed by the display mux
//   LFSR_SEED      : reset value of the delay-randomising LFSR
//   game_sel_of()  : maps a phase onto its display code
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    ARMED = 3'd2,
    GO    = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SEL_IDLE  = 2'b00;
  localparam logic [1:0] SEL_COUNT = 2'b01;
  localparam logic [1:0] SEL_GAME  = 2'b10;
  localparam logic [1:0] SEL_DONE  = 2'b11;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // ARMED and GO share one display code.
  function automatic logic [1:0] game_sel_of(input state_t s);
    case (s)
      COUNT:    game_sel_of = SEL_COUNT;
      ARMED,
      GO:       game_sel_of = SEL_GAME;
      DONE:     game_sel_of = SEL_DONE;
      default:  game_sel_of = SEL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/game_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used to randomise the
// armed delay. Advances every clock, including while the game is idle, so the
// value captured on entry to ARMED depends on how long the player waited.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high; loads LFSR_SEED
//   value  out  current 16-bit LFSR state (never all-zero)
module game_lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  logic feedback;

  // Tap positions 16,14,13,11 are bits 15,13,12,10; maximal length, so a
  // non-zero seed never reaches the all-zero lockup state.
  assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= LFSR_SEED;
    end else begin
      value <= {value[14:0], feedback};
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Phase controller for the reaction-time game:
//   idle -> countdown -> armed (random delay) -> go (timing) -> done
// Measures the player's reaction time in ms from tick_1ms enable pulses.
// All outputs are registered; a phase change is visible one clock after the
// input that caused it.
// Ports:
//   clk, reset (sync, active-high), tick_1ms (1 ms enable pulse),
//   start_btn / player_btn (debounced 1-cycle pulses),
//   game_select[1:0] (00 idle, 01 countdown, 10 armed/go, 11 done),
//   countdown_value[3:0], go_led, reaction_ms[15:0], result_valid (pulse on
//   entry to DONE), timeout, false_start.
// Optional feature: define FALSE_START_DETECT_EN to end the game when the
// player presses during ARMED; otherwise that press is ignored and
// false_start is tied low.
module game_sequencer
  import game_pkg::*;
#(
  parameter int          COUNTDOWN_SECS = 3,
  parameter int          MS_PER_SEC     = 1000,
  parameter int          MIN_DELAY_MS   = 1000,
  parameter logic [15:0] DELAY_MASK     = 16'h07FF,
  parameter int          MAX_MS         = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1ms,
  input  logic        start_btn,
  input  logic        player_btn,
  output logic [1:0]  game_select,
  output logic [3:0]  countdown_value,
  output logic        go_led,
  output logic [15:0] reaction_ms,
  output logic        result_valid,
  output logic        timeout,
  output logic        false_start
);

  localparam logic [15:0] MS_LAST   = 16'(MS_PER_SEC - 1);
  localparam logic [15:0] MIN_DELAY = 16'(MIN_DELAY_MS);
  localparam logic [15:0] MAX_CNT   = 16'(MAX_MS);
  localparam logic [3:0]  SECS      = 4'(COUNTDOWN_SECS);

  state_t      state, state_nxt;
  logic [15:0] ms_cnt, ms_nxt;
  logic [15:0] delay_cnt, delay_nxt;
  logic [15:0] lfsr_value;
  logic [15:0] react_inc;
  logic [3:0]  cv_nxt;
  logic [15:0] react_nxt;
  logic        go_nxt, rv_nxt, to_nxt;
`ifdef FALSE_START_DETECT_EN
  logic        fs_nxt;
`endif

  game_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_value)
  );

  assign react_inc = reaction_ms + 16'd1;

  always_comb begin
    state_nxt = state;
    cv_nxt    = countdown_value;
    ms_nxt    = ms_cnt;
    delay_nxt = delay_cnt;
    react_nxt = reaction_ms;
    go_nxt    = go_led;
    rv_nxt    = 1'b0;
    to_nxt    = timeout;
`ifdef FALSE_START_DETECT_EN
    fs_nxt    = false_start;
`endif
    case (state)
      // A start from DONE is a full restart, identical to a start from IDLE.
      IDLE, DONE: begin
        if (start_btn) begin
          state_nxt = COUNT;
          cv_nxt    = SECS;
          ms_nxt    = '0;
          react_nxt = '0;
          go_nxt    = 1'b0;
          to_nxt    = 1'b0;
`ifdef FALSE_START_DETECT_EN
          fs_nxt    = 1'b0;
`endif
        end
      end
      COUNT: begin
        if (tick_1ms) begin
          if (ms_cnt == MS_LAST) begin
            ms_nxt = '0;
            cv_nxt = countdown_value - 4'd1;
            if (countdown_value == 4'd1) begin
              state_nxt = ARMED;
              delay_nxt = MIN_DELAY + (lfsr_value & DELAY_MASK);
            end
          end else begin
            ms_nxt = ms_cnt + 16'd1;
          end
        end
      end
      ARMED: begin
`ifdef FALSE_START_DETECT_EN
        if (player_btn) begin
          state_nxt = DONE;
          fs_nxt    = 1'b1;
          react_nxt = '0;
          rv_nxt    = 1'b1;
        end else
`endif
        if (tick_1ms) begin
          delay_nxt = delay_cnt - 16'd1;
          if (delay_cnt == 16'd1) begin
            state_nxt = GO;
            react_nxt = '0;
            go_nxt    = 1'b1;
          end
        end
      end
      GO: begin
        // A press coincident with a tick wins: the tick is not counted.
        if (player_btn) begin
          state_nxt = DONE;
          go_nxt    = 1'b0;
          rv_nxt    = 1'b1;
        end else if (tick_1ms) begin
          react_nxt = react_inc;
          if (react_inc >= MAX_CNT) begin
            react_nxt = MAX_CNT;
            state_nxt = DONE;
            go_nxt    = 1'b0;
            to_nxt    = 1'b1;
            rv_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      game_select     <= SEL_IDLE;
      countdown_value <= '0;
      ms_cnt          <= '0;
      delay_cnt       <= '0;
      reaction_ms     <= '0;
      go_led          <= 1'b0;
      result_valid    <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      state           <= state_nxt;
      game_select     <= game_sel_of(state_nxt);
      countdown_value <= cv_nxt;
      ms_cnt          <= ms_nxt;
      delay_cnt       <= delay_nxt;
      reaction_ms     <= react_nxt;
      go_led          <= go_nxt;
      result_valid    <= rv_nxt;
      timeout         <= to_nxt;
    end
  end

`ifdef FALSE_START_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      false_start <= 1'b0;
    end else begin
      false_start <= fs_nxt;
    end
  end
`else
  assign false_start = 1'b0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with reduced timing parameters:
// MS_PER_SEC=4, COUNTDOWN_SECS=3, MIN_DELAY_MS=5, DELAY_MASK=0, MAX_MS=20,
// so the armed delay is a fixed 5 ticks. Inputs change 1 ns after a rising
// edge and outputs are sampled 1 ns after the following rising edge.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick_1ms = 1'b0;
  logic        start_btn = 1'b0;
  logic        player_btn = 1'b0;
  logic [1:0]  game_select;
  logic [3:0]  countdown_value;
  logic        go_led;
  logic [15:0] reaction_ms;
  logic        result_valid;
  logic        timeout;
  logic        false_start;

  int checks = 0;
  int failures = 0;
  int rv_seen;

  game_sequencer #(
    .COUNTDOWN_SECS (3),
    .MS_PER_SEC     (4),
    .MIN_DELAY_MS   (5),
    .DELAY_MASK     (16'h0000),
    .MAX_MS         (20)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tick_1ms        (tick_1ms),
    .start_btn       (start_btn),
    .player_btn      (player_btn),
    .game_select     (game_select),
    .countdown_value (countdown_value),
    .go_led          (go_led),
    .reaction_ms     (reaction_ms),
    .result_valid    (result_valid),
    .timeout         (timeout),
    .false_start     (false_start)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of input pulses, then sample after the edge.
  task automatic step(input logic t, input logic s, input logic p);
    tick_1ms   = t;
    start_btn  = s;
    player_btn = p;
    @(posedge clk);
    #1;
    tick_1ms   = 1'b0;
    start_btn  = 1'b0;
    player_btn = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  // From IDLE or DONE: start, 12 countdown ticks, 5 armed ticks -> GO.
  task automatic run_to_go();
    step(1'b0, 1'b1, 1'b0);
    ticks(17);
  endtask

  initial begin
    // 1. reset state, countdown and arming
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check_val("rst_sel", game_select, 2'b00);
    check_val("rst_cv", countdown_value, 0);
    check_val("rst_go", go_led, 0);
    check_val("rst_react", reaction_ms, 0);
    check_val("rst_rv", result_valid, 0);
    check_val("rst_to", timeout, 0);
    check_val("rst_fs", false_start, 0);

    step(1'b0, 1'b0, 1'b1);
    check_val("idle_press_sel", game_select, 2'b00);
    step(1'b0, 1'b1, 1'b0);
    check_val("cnt_sel", game_select, 2'b01);
    check_val("cnt_cv3", countdown_value, 3);
    ticks(3);
    check_val("cnt_cv3_hold", countdown_value, 3);
    step(1'b0, 1'b1, 1'b0);
    check_val("cnt_start_ignored", countdown_value, 3);
    ticks(1);
    check_val("cnt_cv2", countdown_value, 2);
    ticks(4);
    check_val("cnt_cv1", countdown_value, 1);
    ticks(3);
    check_val("cnt_sel_before_arm", game_select, 2'b01);
    ticks(1);
    check_val("arm_sel", game_select, 2'b10);
    check_val("arm_go", go_led, 0);
    ticks(4);
    check_val("arm_go_4", go_led, 0);
    ticks(1);
    check_val("go_led", go_led, 1);
    check_val("go_sel", game_select, 2'b10);
    check_val("go_react0", reaction_ms, 0);

    // 2. press after 7 ticks
    ticks(7);
    check_val("go_react7", reaction_ms, 7);
    step(1'b0, 1'b0, 1'b1);
    check_val("done_sel", game_select, 2'b11);
    check_val("done_react", reaction_ms, 7);
    check_val("done_rv", result_valid, 1);
    check_val("done_go_off", go_led, 0);
    step(1'b1, 1'b0, 1'b1);
    check_val("done_rv_pulse", result_valid, 0);
    check_val("done_hold_react", reaction_ms, 7);
    check_val("done_hold_sel", game_select, 2'b11);

    // 3. restart from DONE, press coincident with 8th tick
    step(1'b0, 1'b1, 1'b0);
    check_val("restart_sel", game_select, 2'b01);
    check_val("restart_cv", countdown_value, 3);
    check_val("restart_react", reaction_ms, 0);
    ticks(17);
    check_val("t3_go", go_led, 1);
    ticks(7);
    step(1'b1, 1'b0, 1'b1);
    check_val("coinc_react", reaction_ms, 7);
    check_val("coinc_sel", game_select, 2'b11);
    check_val("coinc_rv", result_valid, 1);

    // 4. timeout
    run_to_go();
    check_val("t4_go", go_led, 1);
    rv_seen = 0;
    for (int i = 0; i < 19; i++) begin
      step(1'b1, 1'b0, 1'b0);
      rv_seen += int'(result_valid);
    end
    check_val("to_react19", reaction_ms, 19);
    check_val("to_flag19", timeout, 0);
    check_val("to_sel19", game_select, 2'b10);
    step(1'b1, 1'b0, 1'b0);
    rv_seen += int'(result_valid);
    check_val("to_react20", reaction_ms, 20);
    check_val("to_flag", timeout, 1);
    check_val("to_sel", game_select, 2'b11);
    check_val("to_go_off", go_led, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, i == 1);
      rv_seen += int'(result_valid);
    end
    check_val("to_rv_once", rv_seen, 1);
    check_val("to_react_sat", reaction_ms, 20);
    check_val("to_flag_hold", timeout, 1);

    // 5. press during ARMED
    step(1'b0, 1'b1, 1'b0);
    check_val("t5_to_cleared", timeout, 0);
    ticks(14);
    check_val("t5_armed", game_select, 2'b10);
    step(1'b0, 1'b0, 1'b1);
`ifdef FALSE_START_DETECT_EN
    check_val("fs_sel", game_select, 2'b11);
    check_val("fs_flag", false_start, 1);
    check_val("fs_rv", result_valid, 1);
    check_val("fs_react", reaction_ms, 0);
    run_to_go();
    check_val("fs_cleared", false_start, 0);
`else
    check_val("nofs_sel", game_select, 2'b10);
    check_val("nofs_flag", false_start, 0);
    check_val("nofs_rv", result_valid, 0);
    check_val("nofs_go", go_led, 0);
    ticks(3);
    check_val("nofs_go_on", go_led, 1);
`endif

    // 6. reset while in GO, then normal run and restart from DONE
    check_val("t6_in_go", go_led, 1);
    ticks(2);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    check_val("rstgo_sel", game_select, 2'b00);
    check_val("rstgo_go", go_led, 0);
    check_val("rstgo_react", reaction_ms, 0);
    check_val("rstgo_rv", result_valid, 0);
    step(1'b1, 1'b0, 1'b0);
    check_val("rstgo_idle_hold", game_select, 2'b00);
    run_to_go();
    ticks(3);
    step(1'b0, 1'b0, 1'b1);
    check_val("t6_react3", reaction_ms, 3);
    check_val("t6_done", game_select, 2'b11);
    step(1'b0, 1'b1, 1'b0);
    check_val("t6_restart_sel", game_select, 2'b01);
    check_val("t6_restart_cv", countdown_value, 3);
    check_val("t6_restart_react", reaction_ms, 0);
    check_val("t6_restart_to", timeout, 0);
    check_val("t6_restart_fs", false_start, 0);
    check_val("t6_restart_rv", result_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
